// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and helpers: data-memory FSM states and
// big-endian byte-lane extraction/merging.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] sext_byte(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Plain word array: synchronous write, asynchronous read. Shared with the
// instruction memory.
module dmem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[a] <= wd;
  end

  assign rd = mem[a];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: wait-state FSM, big-endian byte lane steering and
// misalignment flagging in front of a word RAM.
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic        byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req;
  logic        stall_c;
  logic        complete;
  logic        ram_we;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] word_rd;
  logic [31:0] word_wd;
  logic        unused_addr;

  assign req         = memwrite | memread;
  assign idx         = addr[AW+1:2];
  assign lane        = addr[1:0];
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = (WAIT_CYCLES == 1) ? DONE : BUSY;
          end
        end
      end
      BUSY: begin
        // Request withdrawn mid-access: abandon it without writing.
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte stores are read-modify-write over the async read port.
  assign word_wd = byte_enable ? lane_merge(word_rd, lane, wd[7:0]) : wd;
  assign ram_we  = complete & memwrite & ~reset;

  dmem_ram #(
    .DEPTH(DEPTH_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk(clk),
    .we (ram_we),
    .a  (idx),
    .wd (word_wd),
    .rd (word_rd)
  );

  always_comb begin
    rd = 32'd0;
    if (complete && !reset) begin
      rd = byte_enable ? sext_byte(lane_byte(word_rd, lane)) : word_rd;
    end
  end

  assign stall    = stall_c & ~reset;
  assign misalign = complete & req & ~byte_enable & (lane != 2'd0) & ~reset;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a zero-wait and a two-wait instance checked against
// an array model of the byte-addressed, big-endian memory.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite[2];
  logic        memread[2];
  logic        byte_enable[2];
  logic [31:0] addr[2];
  logic [31:0] wd[2];
  logic [31:0] rd[2];
  logic        stall[2];
  logic        misalign[2];

  logic [31:0] model[2][DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(0)
  ) u_dut_w0 (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite[0]),
    .memread    (memread[0]),
    .byte_enable(byte_enable[0]),
    .addr       (addr[0]),
    .wd         (wd[0]),
    .rd         (rd[0]),
    .stall      (stall[0]),
    .misalign   (misalign[0])
  );

  dmem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(2)
  ) u_dut_w2 (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite[1]),
    .memread    (memread[1]),
    .byte_enable(byte_enable[1]),
    .addr       (addr[1]),
    .wd         (wd[1]),
    .rd         (rd[1]),
    .stall      (stall[1]),
    .misalign   (misalign[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int waits(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // One complete access on instance k, checked against the model, then one idle cycle.
  task automatic access(input int k, input bit w, input bit r, input bit be,
                        input logic [31:0] a, input logic [31:0] d);
    int          idx;
    int          sh;
    int          n_stall;
    int          n_mis;
    bit          done;
    logic [31:0] old;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    idx = int'((a >> 2) % DEPTH);
    sh  = 8 * (3 - int'(a[1:0]));
    old = model[k][idx];
    b   = (old >> sh) & 32'hFF;
    exp_rd = be ? (b[7] ? (b | 32'hFFFF_FF00) : b) : old;

    @(posedge clk); #1;
    memwrite[k] = w; memread[k] = r; byte_enable[k] = be; addr[k] = a; wd[k] = d;
    n_stall = 0; n_mis = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall[k]) begin
        n_stall++;
        if (misalign[k]) n_mis++;
      end else begin
        done = 1'b1;
        check($sformatf("stall_cycles[%0d]", k), n_stall, waits(k));
        check($sformatf("misalign_early[%0d]", k), n_mis, 0);
        check($sformatf("misalign[%0d]", k), {31'd0, misalign[k]},
              {31'd0, (!be && a[1:0] != 2'd0)});
        if (r) check($sformatf("rd[%0d] a=%h", k, a), rd[k], exp_rd);
      end
    end
    if (!done) check($sformatf("timeout[%0d]", k), 32'd0, 32'd1);

    if (w) begin
      if (be) begin
        mask = 32'hFF << sh;
        model[k][idx] = (old & ~mask) | ((d & 32'hFF) << sh);
      end else begin
        model[k][idx] = d;
      end
    end

    @(posedge clk); #1;
    memwrite[k] = 1'b0; memread[k] = 1'b0;
    @(negedge clk);
    check($sformatf("idle_out[%0d]", k), {rd[k][30:0], stall[k] | misalign[k]}, 32'd0);
  endtask

  initial begin
    logic [31:0] old9;
    int          op;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      memwrite[k] = 1'b0; memread[k] = 1'b0; byte_enable[k] = 1'b0;
      addr[k] = 32'd0; wd[k] = 32'd0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_stall[%0d]", k), {31'd0, stall[k]}, 32'd0);
      check($sformatf("reset_misalign[%0d]", k), {31'd0, misalign[k]}, 32'd0);
      check($sformatf("reset_rd[%0d]", k), rd[k], 32'd0);
    end
    @(negedge clk); reset = 1'b0;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++) access(k, 1'b1, 1'b0, 1'b0, 32'(i * 4), $urandom);

    // Directed cases on the two-wait instance.
    access(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("mem4_after_sw", model[1][4], 32'hDEAD_BEEF);
    access(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h1122_3344);
    access(1, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0000_00A5);
    access(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b0, 1'b1, 1'b1, 32'h11, 32'h0);
    access(1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    access(1, 1'b0, 1'b1, 1'b0, 32'h12, 32'h0);
    access(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0BAD_F00D);
    access(1, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0);

    // Zero-wait instance: address wrap and misaligned word read.
    access(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    access(0, 1'b0, 1'b1, 1'b0, 32'h12, 32'h0);
    access(0, 1'b1, 1'b0, 1'b1, 32'h203, 32'h0000_0080);
    access(0, 1'b0, 1'b1, 1'b1, 32'h3, 32'h0);

    // Reset during BUSY aborts the store.
    old9 = model[1][9];
    @(posedge clk); #1;
    memwrite[1] = 1'b1; byte_enable[1] = 1'b0; addr[1] = 32'h24; wd[1] = ~old9;
    @(negedge clk);
    check("abort_first_stall", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_stall_drop", {31'd0, stall[1]}, 32'd0);
    check("abort_rd", rd[1], 32'd0);
    @(negedge clk);
    memwrite[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access(1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
    check("abort_model_kept", model[1][9], old9);

    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < 2; k++) begin
        op = int'($urandom_range(0, 2));
        access(k, op != 0, op != 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
